// File: rtl/bcd_seg_scan4.sv
// Four-digit multiplexed seven-segment scanner for a common-anode display.
// Digits are captured into a pending bank on load and promoted to the
// display bank only at a frame boundary, so a refresh never mixes data.
module bcd_seg_scan4 #(
    parameter int PRESCALE = 2500,
    parameter int GUARD    = 2,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    input  logic [3:0] dp_sel,
    input  logic       load,
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    slot;
    logic [3:0]    pa, pb, pc, pd, pdp;
    logic [3:0]    ra, rb, rc, rd, rdp;

    logic       cnt_last;
    logic       boundary;
    logic       guard;
    logic       blank;
    logic [3:0] digit;
    logic [3:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    assign cnt_last = (cnt == CW'(PRESCALE - 1));
    assign boundary = cnt_last && (slot == 2'd3);
    assign guard    = (int'(cnt) < GUARD);

    // Slot timebase: prescaler wraps once per slot, slot walks A,B,C,D.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            slot <= 2'd0;
        end else if (cnt_last) begin
            cnt  <= '0;
            slot <= slot + 2'd1;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

    // Pending/display banks; a load on the boundary edge bypasses pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {pa, pb, pc, pd, pdp} <= '0;
            {ra, rb, rc, rd, rdp} <= '0;
            busy                  <= 1'b0;
            frame_done            <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (boundary) begin
                busy <= 1'b0;
                if (load) begin
                    {ra, rb, rc, rd, rdp} <= {A, B, C, D, dp_sel};
                    {pa, pb, pc, pd, pdp} <= {A, B, C, D, dp_sel};
                end else if (busy) begin
                    {ra, rb, rc, rd, rdp} <= {pa, pb, pc, pd, pdp};
                end
            end else if (load) begin
                {pa, pb, pc, pd, pdp} <= {A, B, C, D, dp_sel};
                busy                  <= 1'b1;
            end
        end
    end

    // Current digit select, leading-zero blanking and segment decode.
    always_comb begin
        digit = rd;
        blank = 1'b0;
        case (slot)
            2'd0: begin digit = ra; blank = (ra == 4'd0); end
            2'd1: begin digit = rb; blank = (ra == 4'd0) && (rb == 4'd0); end
            2'd2: begin digit = rc; blank = (ra == 4'd0) && (rb == 4'd0) && (rc == 4'd0); end
            default: begin digit = rd; blank = 1'b0; end
        endcase
        if (BLANK_LZ == 0) blank = 1'b0;

        case (digit)
            4'd0:    seg_nxt = 7'b1000000;
            4'd1:    seg_nxt = 7'b1111001;
            4'd2:    seg_nxt = 7'b0100100;
            4'd3:    seg_nxt = 7'b0110000;
            4'd4:    seg_nxt = 7'b0011001;
            4'd5:    seg_nxt = 7'b0010010;
            4'd6:    seg_nxt = 7'b0000010;
            4'd7:    seg_nxt = 7'b1111000;
            4'd8:    seg_nxt = 7'b0000000;
            4'd9:    seg_nxt = 7'b0010000;
            default: seg_nxt = 7'b0111111;
        endcase
        if (blank) seg_nxt = 7'b1111111;

        an_nxt = guard ? 4'b1111 : ~(4'b1000 >> slot);
        // ~slot maps slot 0 (A) to dp bit 3.
        dp_nxt = guard ? 1'b1 : ~rdp[~slot];
    end

    // Registered pin drive, one cycle behind the timebase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan4.sv
// Scoreboard bench: the driver pushes the frame content expected after each
// boundary; a monitor pops one entry per frame and checks every slot.
module tb_bcd_seg_scan4;

    localparam int P  = 8;
    localparam int G  = 2;
    localparam int FR = 4 * P;
    localparam int NF = 14;

    typedef struct packed {
        logic [15:0] digs;   // {A,B,C,D}
        logic [3:0]  dps;    // bit3=A .. bit0=D
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] A = '0, B = '0, C = '0, D = '0, dp_sel = '0;
    logic       load = 1'b0;
    logic       busy, frame_done, dp;
    logic [3:0] an;
    logic [6:0] seg;
    logic       busy2, frame_done2, dp2;
    logic [3:0] an2;
    logic [6:0] seg2;

    bcd_seg_scan4 #(.PRESCALE(P), .GUARD(G), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .dp_sel(dp_sel),
        .load(load), .busy(busy), .frame_done(frame_done), .an(an),
        .seg(seg), .dp(dp));

    bcd_seg_scan4 #(.PRESCALE(P), .GUARD(G), .BLANK_LZ(0)) dut_nl (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .dp_sel(dp_sel),
        .load(load), .busy(busy2), .frame_done(frame_done2), .an(an2),
        .seg(seg2), .dp(dp2));

    always #5 clk = ~clk;

    // Edges since reset release.
    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    frame_t exp_q[$];
    frame_t cur;
    bit     busy_m;
    bit     mon_done;
    int     n_chk;
    int     n_err;

    task automatic cmp(input string name, input int got, input int expv);
        n_chk++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
              7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        return t[d];
    endfunction

    // A digit left of D is blank when every digit from A up to it is zero.
    function automatic logic [6:0] exp_seg(input frame_t f, input int s, input bit lz);
        bit lead = 1'b1;
        for (int i = 0; i <= s; i++)
            if (f.digs[15 - 4*i -: 4] != 4'd0) lead = 1'b0;
        if (lz && s < 3 && lead) return 7'b1111111;
        return seg_of(f.digs[15 - 4*s -: 4]);
    endfunction

    function automatic frame_t mk(input int a, input int b, input int c, input int d, input logic [3:0] dps);
        frame_t f;
        f.digs = {a[3:0], b[3:0], c[3:0], d[3:0]};
        f.dps  = dps;
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < 4; i++)
            f.digs[15 - 4*i -: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
        f.dps = 4'($urandom % 16);
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample k of a frame reflects slot k/P at prescaler phase k%P.
    task automatic check_sample(input frame_t f, input int k);
        int s;
        int c;
        logic [3:0] ea;
        s = k / P;
        c = k % P;
        if (c == 0 || c == G || c == P - 1) begin
            if (c < G) begin
                cmp("an_guard", an, 4'hF);
                cmp("dp_guard", dp, 1);
            end else begin
                ea = ~(4'b1000 >> s);
                cmp("an", an, ea);
                cmp("seg", seg, exp_seg(f, s, 1'b1));
                cmp("seg_nolz", seg2, exp_seg(f, s, 1'b0));
                cmp("dp", dp, !f.dps[3 - s]);
            end
        end
    endtask

    // One clock edge of stimulus; the model tracks latest data and busy.
    task automatic do_edge(input bit ld, input frame_t v);
        if (ld) begin
            {A, B, C, D} = v.digs;
            dp_sel = v.dps;
            load = 1'b1;
        end
        step();
        load = 1'b0;
        if (ld) begin
            cur = v;
            busy_m = 1'b1;
        end
        if (cyc % FR == 0) begin
            busy_m = 1'b0;
            exp_q.push_back(cur);
        end
        cmp("busy", busy, busy_m);
    endtask

    task automatic load_at(input int e, input frame_t v);
        while (cyc < e - 1) do_edge(1'b0, '0);
        do_edge(1'b1, v);
    endtask

    task automatic monitor();
        frame_t f;
        f = '0;
        for (int j = 0; j <= NF; j++) begin
            for (int k = 0; k < FR; k++) begin
                step();
                if (k == 0) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL queue_underflow: got empty expected entry (cyc %0d)", cyc);
                        f = '0;
                    end else begin
                        f = exp_q.pop_front();
                    end
                end
                check_sample(f, k);
                if (k == P - 1) cmp("frame_done_mid", frame_done, 0);
            end
            cmp("frame_done", frame_done, 1);
        end
        mon_done = 1'b1;
    endtask

    task automatic check_reset_values();
        cmp("rst_an", an, 4'hF);
        cmp("rst_seg", seg, 7'h7F);
        cmp("rst_seg_nolz", seg2, 7'h7F);
        cmp("rst_dp", dp, 1);
        cmp("rst_busy", busy, 0);
        cmp("rst_frame_done", frame_done, 0);
    endtask

    initial begin
        int e;
        n_chk    = 0;
        n_err    = 0;
        cur      = '0;
        busy_m   = 1'b0;
        mon_done = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values();

        exp_q.push_back('0);
        @(negedge clk);
        rst = 1'b1;
        fork
            monitor();
        join_none

        load_at(44,  mk(1, 2, 3, 4, 4'b0010));
        load_at(84,  mk(0, 0, 0, 7, 4'b0000));
        load_at(100, mk(1, 1, 1, 1, 4'b1111));
        load_at(120, mk(5, 6, 7, 8, 4'b0000));
        load_at(160, mk(9, 9, 9, 9, 4'b1000));
        load_at(170, mk(0, 12, 0, 3, 4'b0000));
        while (cyc < FR * NF) do_edge($urandom % 12 == 0, rand_frame());

        for (int i = 0; i < 3 * FR && !mon_done; i++) do_edge(1'b0, '0);
        if (!mon_done) begin
            n_chk++;
            n_err++;
            $display("FAIL monitor_timeout: got running expected done (cyc %0d)", cyc);
        end

        // Reset while data is pending: it must never reach the display.
        e = cyc + 3;
        if (e % FR == 0) e++;
        load_at(e, mk(8, 8, 8, 8, 4'hF));
        do_edge(1'b0, '0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values();
        cur    = '0;
        busy_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2 * FR; k++) begin
            step();
            check_sample('0, k % FR);
        end
        cmp("busy_after_rst", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
